// File: rtl/toggle_counter_pkg.sv
// Shared definitions for the toggle_counter block: direction encoding and the
// next-count helper used by both the counter and its reference model.
package toggle_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Next value of a modulo counter; operands are zero-extended to 32 bits.
    function automatic logic [31:0] tc_next(input logic [31:0] q,
                                            input logic        up,
                                            input logic [31:0] modulus);
        logic [31:0] nxt;
        if (up == DIR_UP)
            nxt = (q == modulus - 32'd1) ? 32'd0 : q + 32'd1;
        else
            nxt = (q == 32'd0) ? modulus - 32'd1 : q - 32'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH parallel T flip-flops; each bit inverts when its toggle input
// is high at a rising clock edge.
module tff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else
            q <= q ^ t;
    end

endmodule

// File: rtl/toggle_counter.sv
// Up/down modulo counter whose count lives only in a T flip-flop bank; every
// update, including parallel load, is expressed as a toggle vector.
module toggle_counter
    import toggle_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             load_err
);

    generate
        if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_params
            $error("toggle_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
        end
    endgenerate

    // One extra bit so MODULUS == 2**WIDTH is representable in the load check.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] t;
    logic             tc_d;
    logic             load_err_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_q     = q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if ({1'b0, load_val} < MOD_EXT)
                next_q = load_val;
            else
                load_err_d = 1'b1;
        end else if (en) begin
            next_q = WIDTH'(tc_next(32'(q), up, 32'(MODULUS)));
            tc_d   = (up == DIR_UP) ? (q == MAX_Q) : (q == '0);
        end
    end

    assign t = q ^ next_q;

    tff_bank #(.WIDTH(WIDTH)) u_bank (
        .clk   (clk),
        .reset (reset),
        .t     (t),
        .q     (q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tc       <= tc_d;
            load_err <= load_err_d;
        end
    end

endmodule

// File: doc/toggle_counter.md
# toggle_counter

Parametrised synchronous up/down modulo counter built from a bank of T flip-flops, the multi-bit successor to the single-bit T flip-flop. Each cycle the block computes a per-bit toggle vector from the current count, direction and modulus, then applies it to the T flip-flop bank. It adds enable, synchronous parallel load, programmable modulus wrap, a terminal-count pulse and a load-error pulse. It serves as the general-purpose counter and divider primitive for the flip-flop library.

## Interface
- `WIDTH`, 4, count width in bits; legal range is WIDTH ≥ 1.
- `MODULUS`, 16, count range 0..MODULUS-1; legal range is 2 ≤ MODULUS ≤ 2**WIDTH.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `en`  in  1  count enable.
- `up`  in  1  direction: 1 = up, 0 = down.
- `load`  in  1  synchronous parallel load request.
- `load_val`  in  WIDTH  value to load.
- `q`  out  WIDTH  current count (registered).
- `tc`  out  1  terminal-count pulse, registered.
- `load_err`  out  1  rejected-load pulse, registered.

## Operation
- **Reset (`reset`=0):** `q`=0, `tc`=0, `load_err`=0, immediately and independent of `clk`. Reset held low freezes all outputs. Deassertion is seen at the next rising edge.
- **Priority per edge:** load > en > hold.
- **Load (`load`=1):**
  - If `load_val` < MODULUS: `q` ← `load_val`, `tc`=0, `load_err`=0.
  - If `load_val` ≥ MODULUS: `q` holds, `load_err`=1 for one cycle, `tc`=0.
  - `en` is ignored in the load cycle in both cases.
- **Count (`load`=0, `en`=1):**
  - Up: `q`==MODULUS-1 → `q` ← 0 and `tc`=1; otherwise `q` ← `q`+1 and `tc`=0.
  - Down: `q`==0 → `q` ← MODULUS-1 and `tc`=1; otherwise `q` ← `q`-1 and `tc`=0.
- **Hold (`load`=0, `en`=0):** `q` unchanged, `tc`=0, `load_err`=0.
- **Toggle vector:** t = `q` XOR next_q.
  - Only the T flip-flop bank stores `q`; no separate D register for the count.
  - Load is also applied as a toggle vector (`q` XOR `load_val`).
- **Direction change:** `up` may change on any cycle. It takes effect on the next counting edge; no state is kept between cycles.
- **Arithmetic:** all comparisons are unsigned and WIDTH bits wide. With MODULUS = 2**WIDTH the wrap equals natural binary overflow. `q` never leaves 0..MODULUS-1.
- **No state machine:** the block has no states beyond `q` itself.

## Timing
- Every output is registered; there is no combinational path from input to output.
- **Latency:** inputs sampled at edge N appear on `q`/`tc`/`load_err` after edge N. `tc` is aligned with the wrapped value of `q`.
- `tc` and `load_err` are high for exactly one cycle per event.
  - Back-to-back wraps (MODULUS=2, `en` held high) give `tc` high on every cycle.
  - Back-to-back bad loads give `load_err` high on every cycle.
- **Reset mid-count:** outputs go to 0 asynchronously; any pending `tc`/`load_err` is cleared.
- **Reset and load:** reset wins over a simultaneous `load`.

## Structure
- **Package `toggle_counter_pkg`:**
  - localparams `DIR_UP`=1'b1, `DIR_DOWN`=1'b0.
  - function `tc_next(q, up, modulus)` returning next_q; shared by the RTL and the bench reference model.
- **Sub-module `tff_bank`:**
  - params: `WIDTH`.
  - ports: `clk`, `reset` (async, active-low), `t[WIDTH]`, `q[WIDTH]`.
  - WIDTH parallel T flip-flops, reset to 0. The counter instantiates one bank.
- **Top level:** toggle-vector and control logic, plus the two registered flags.
- **Elaboration check:** illegal WIDTH/MODULUS combinations (MODULUS < 2 or MODULUS > 2**WIDTH) fail at elaboration.

## Test plan
All scenarios use WIDTH=4, MODULUS=10 unless stated.
- **Reset:** `reset`=0 asserted asynchronously mid-cycle with `q`=7 → `q`=0, `tc`=0, `load_err`=0 immediately, without waiting for an edge. After release with `en`=1, `up`=1 → `q` = 1, 2, 3 on successive edges.
- **Up wrap:** `en`=1, `up`=1 from `q`=8 → `q` = 9, 0, 1. `tc`=1 only in the cycle `q`=0.
- **Down wrap and direction switch:** `en`=1, `up`=0 from `q`=1 → `q` = 0, 9 with `tc`=1 at `q`=9. Then `up`=1 → `q`=0 with `tc`=1.
- **Load legal/illegal and priority:**
  - `load`=1, `load_val`=5, `en`=1 → `q`=5, `load_err`=0.
  - Next cycle `load_val`=12 → `q` stays 5, `load_err`=1 for one cycle.
  - `load_val`=9 then count up → `q`=0 with `tc`=1.
- **Hold and full-range:**
  - `en`=0 for 5 cycles at `q`=3 → `q` stays 3, no pulses.
  - Re-parametrise WIDTH=3, MODULUS=8, count up from 7 → `q`=0 with `tc`=1. Random up/down/load stimulus over 1000 cycles matches `tc_next` every cycle.
